hazard_fwd_ctrl: RTL and testbench

//  Pipeline hazard controller for the 5-stage RV32I core (IF/ID/EX/MEM/WB).

---
 rtl/hazard_fwd_ctrl.sv | 157 +++++++++++++++
 tb/tb_hazard_fwd_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_ctrl.sv
// hazard_fwd_ctrl: hazard controller for the 5-stage RV32I pipeline.
//   Tracks destination registers of in-flight instructions (EX/MEM/WB), drives
//   the EX operand-forwarding selects, stalls on load-use (or on any RAW hazard
//   when forwarding is disabled), flushes IF/ID on taken branches and keeps
//   saturating stall/flush event counters.
// Ports:
//   clk, rst                    clock (rising edge), async active-high reset
//   id_valid, id_rs1/2,         ID-stage instruction: validity, sources and
//   id_rs1/2_used, id_rd,       whether they are read, destination, write
//   id_rd_we, id_is_load        enable and load flag
//   ex_br_taken                 taken branch/jump resolved in EX this cycle
//   stall, flush_if_id,         comb: freeze PC+IF/ID, clear IF/ID,
//   id_ex_bubble                load NOP into ID/EX
//   ex_fwd_a_sel, ex_fwd_b_sel  reg: EX operand mux selects (0 RF, 1 MEM, 2 WB)
//   stall_cnt, flush_cnt        reg: saturating event counters
module hazard_fwd_ctrl #(
   parameter int unsigned REG_AW = 5,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned FWD_EN = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs1,
   input  logic [REG_AW-1:0] id_rs2,
   input  logic              id_rs1_used,
   input  logic              id_rs2_used,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_rd_we,
   input  logic              id_is_load,
   input  logic              ex_br_taken,
   output logic              stall,
   output logic              flush_if_id,
   output logic              id_ex_bubble,
   output logic [1:0]        ex_fwd_a_sel,
   output logic [1:0]        ex_fwd_b_sel,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [1:0] SEL_RF  = 2'd0;
   localparam logic [1:0] SEL_MEM = 2'd1;
   localparam logic [1:0] SEL_WB  = 2'd2;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              we;
      logic              load;
   } ex_slot_t;

   // The load flag only matters while the producer is in EX, so MEM drops it.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic              we;
   } mem_slot_t;

   // The WB slot holds no state: the register file is write-first, so a
   // producer in WB never forwards or stalls and nothing would read it.
   ex_slot_t  ex_q;
   mem_slot_t mem_q;

   logic       hz_ex, hz_mem, advancing;
   logic [1:0] a_nxt, b_nxt;

   function automatic logic match_ex(input logic used, input logic [REG_AW-1:0] rs,
                                     input ex_slot_t s);
      return used & s.valid & s.we & (s.rd != '0) & (s.rd == rs);
   endfunction

   function automatic logic match_mem(input logic used, input logic [REG_AW-1:0] rs,
                                      input mem_slot_t s);
      return used & s.valid & s.we & (s.rd != '0) & (s.rd == rs);
   endfunction

   // Forward select for one operand: youngest producer wins.
   function automatic logic [1:0] fwd_sel(input logic used, input logic [REG_AW-1:0] rs,
                                          input ex_slot_t e, input mem_slot_t m);
      if (match_ex(used, rs, e))
         return SEL_MEM;
      else if (match_mem(used, rs, m))
         return SEL_WB;
      else
         return SEL_RF;
   endfunction

   // Hazard detection, stall/flush/bubble and next forward selects.
   always_comb begin
      hz_ex        = 1'b0;
      hz_mem       = 1'b0;
      stall        = 1'b0;
      flush_if_id  = 1'b0;
      id_ex_bubble = 1'b0;
      advancing    = 1'b0;
      a_nxt        = SEL_RF;
      b_nxt        = SEL_RF;

      hz_ex  = match_ex(id_rs1_used, id_rs1, ex_q) | match_ex(id_rs2_used, id_rs2, ex_q);
      hz_mem = match_mem(id_rs1_used, id_rs1, mem_q) | match_mem(id_rs2_used, id_rs2, mem_q);

      // Flush takes priority: a taken branch kills the ID instruction anyway.
      if (id_valid && !ex_br_taken) begin
         if (FWD_EN != 0)
            stall = hz_ex & ex_q.load;
         else
            stall = hz_ex | hz_mem;
      end

      flush_if_id  = ex_br_taken;
      id_ex_bubble = stall | ex_br_taken | ~id_valid;
      advancing    = id_valid & ~stall & ~ex_br_taken;

      if (advancing && (FWD_EN != 0)) begin
         a_nxt = fwd_sel(id_rs1_used, id_rs1, ex_q, mem_q);
         b_nxt = fwd_sel(id_rs2_used, id_rs2, ex_q, mem_q);
      end
   end

   // Scoreboard shift and registered forward selects.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_q         <= '0;
         mem_q        <= '0;
         ex_fwd_a_sel <= SEL_RF;
         ex_fwd_b_sel <= SEL_RF;
      end else begin
         mem_q.valid  <= ex_q.valid;
         mem_q.rd     <= ex_q.rd;
         mem_q.we     <= ex_q.we;
         if (advancing) begin
            ex_q.valid <= 1'b1;
            ex_q.rd    <= id_rd;
            ex_q.we    <= id_rd_we;
            ex_q.load  <= id_is_load;
         end else begin
            ex_q       <= '0;
         end
         ex_fwd_a_sel <= a_nxt;
         ex_fwd_b_sel <= b_nxt;
      end
   end

   // Saturating event counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_if_id && (flush_cnt != {CNT_W{1'b1}}))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Testbench for hazard_fwd_ctrl: table-driven per-cycle vectors on a
// forwarding instance, plus hand sequences on a no-forwarding instance with a
// 2-bit counter for the multi-cycle stall, saturation and mid-stall reset.
module tb_hazard_fwd_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       id_valid;
   logic [4:0] id_rs1, id_rs2, id_rd;
   logic       id_rs1_used, id_rs2_used, id_rd_we, id_is_load, ex_br_taken;

   logic        stall, flush_if_id, id_ex_bubble;
   logic [1:0]  a_sel, b_sel;
   logic [31:0] stall_cnt, flush_cnt;

   logic        stall0, flush0, bubble0;
   logic [1:0]  a_sel0, b_sel0;
   logic [1:0]  stall_cnt0, flush_cnt0;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(32), .FWD_EN(1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_rd_we(id_rd_we), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
      .stall(stall), .flush_if_id(flush_if_id), .id_ex_bubble(id_ex_bubble),
      .ex_fwd_a_sel(a_sel), .ex_fwd_b_sel(b_sel),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt));

   hazard_fwd_ctrl #(.REG_AW(5), .CNT_W(2), .FWD_EN(0)) dut0 (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
      .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
      .id_rd_we(id_rd_we), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
      .stall(stall0), .flush_if_id(flush0), .id_ex_bubble(bubble0),
      .ex_fwd_a_sel(a_sel0), .ex_fwd_b_sel(b_sel0),
      .stall_cnt(stall_cnt0), .flush_cnt(flush_cnt0));

   typedef struct {
      logic       v;
      logic [4:0] rs1, rs2;
      logic       u1, u2;
      logic [4:0] rd;
      logic       we, ld, br;
      logic       e_stall, e_flush, e_bub;
      logic [1:0] e_a, e_b;
      int         e_scnt, e_fcnt;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic row(input logic v, input int rs1, input int rs2, input logic u1,
                      input logic u2, input int rd, input logic we, input logic ld,
                      input logic br, input logic st, input logic fl, input logic bu,
                      input int a, input int b, input int sc, input int fc);
      vec_t r;
      r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1; r.u2 = u2;
      r.rd = 5'(rd); r.we = we; r.ld = ld; r.br = br;
      r.e_stall = st; r.e_flush = fl; r.e_bub = bu;
      r.e_a = 2'(a); r.e_b = 2'(b); r.e_scnt = sc; r.e_fcnt = fc;
      tbl.push_back(r);
   endtask

   task automatic drive(input logic v, input int rs1, input int rs2, input logic u1,
                        input logic u2, input int rd, input logic we, input logic ld,
                        input logic br);
      id_valid = v; id_rs1 = 5'(rs1); id_rs2 = 5'(rs2);
      id_rs1_used = u1; id_rs2_used = u2; id_rd = 5'(rd);
      id_rd_we = we; id_is_load = ld; ex_br_taken = br;
   endtask

   initial begin
      // v rs1 rs2 u1 u2 rd we ld br | stall flush bub a b scnt fcnt
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 0,0, 0,0);
      row(1, 1, 2, 1,1,  5,1,0,0,  0,0,0, 0,0, 0,0); // add x5
      row(1, 5, 0, 1,0,  6,1,0,0,  0,0,0, 0,0, 0,0); // reads x5 from EX
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 1,0, 0,0); // a_sel=1
      row(1, 0, 0, 0,0,  5,1,0,0,  0,0,0, 0,0, 0,0); // add x5
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 0,0, 0,0); // gap: x5 to MEM
      row(1, 1, 5, 1,1,  8,1,0,0,  0,0,0, 0,0, 0,0); // rs2=x5 from MEM
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 0,2, 0,0); // b_sel=2
      row(1, 0, 0, 0,0,  9,1,0,0,  0,0,0, 0,0, 0,0); // add x9 (older)
      row(1, 0, 0, 0,0,  9,1,0,0,  0,0,0, 0,0, 0,0); // add x9 (younger)
      row(1, 9, 9, 1,1,  0,0,0,0,  0,0,0, 0,0, 0,0); // both in EX and MEM
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 1,1, 0,0); // youngest wins
      row(1, 0, 0, 0,0,  7,1,1,0,  0,0,0, 0,0, 0,0); // lw x7
      row(1, 7, 0, 1,0, 10,1,0,0,  1,0,1, 0,0, 0,0); // load-use stall
      row(1, 7, 0, 1,0, 10,1,0,0,  0,0,0, 0,0, 1,0); // advances
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 2,0, 1,0); // a_sel=2
      row(1, 0, 0, 0,0,  0,1,1,0,  0,0,0, 0,0, 1,0); // lw x0
      row(1, 0, 0, 1,1,  0,0,0,0,  0,0,0, 0,0, 1,0); // reads x0: no stall
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 0,0, 1,0); // sel stays 0
      row(1, 0, 0, 0,0,  7,1,1,0,  0,0,0, 0,0, 1,0); // lw x7
      row(1, 7, 0, 1,0, 10,1,0,1,  0,1,1, 0,0, 1,0); // flush beats stall
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 0,0, 1,1);
      row(0, 0, 0, 0,0,  0,0,0,1,  0,1,1, 0,0, 1,1); // flush, empty ID
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 0,0, 1,2);
      row(1, 0, 0, 0,0, 11,1,1,0,  0,0,0, 0,0, 1,2); // lw x11
      row(1,11,11, 0,1,  0,0,0,0,  1,0,1, 0,0, 1,2); // rs2-only use stalls
      row(1,11,11, 0,1,  0,0,0,0,  0,0,0, 0,0, 2,2);
      row(0, 0, 0, 0,0,  0,0,0,0,  0,0,1, 0,2, 2,2); // b=2, a unused -> 0

      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      repeat (2) @(negedge clk);
      #1;
      chk("rst_stall",  32'(stall), 0);
      chk("rst_bubble", 32'(id_ex_bubble), 1);
      chk("rst_a",      32'(a_sel), 0);
      chk("rst_b",      32'(b_sel), 0);
      chk("rst_scnt",   stall_cnt, 0);
      chk("rst_fcnt",   flush_cnt, 0);
      @(negedge clk);
      rst = 1'b0;

      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i].v, 32'(tbl[i].rs1), 32'(tbl[i].rs2), tbl[i].u1, tbl[i].u2,
               32'(tbl[i].rd), tbl[i].we, tbl[i].ld, tbl[i].br);
         #1;
         chk($sformatf("r%0d_stall", i),  32'(stall),        32'(tbl[i].e_stall));
         chk($sformatf("r%0d_flush", i),  32'(flush_if_id),  32'(tbl[i].e_flush));
         chk($sformatf("r%0d_bubble", i), 32'(id_ex_bubble), 32'(tbl[i].e_bub));
         chk($sformatf("r%0d_a_sel", i),  32'(a_sel),        32'(tbl[i].e_a));
         chk($sformatf("r%0d_b_sel", i),  32'(b_sel),        32'(tbl[i].e_b));
         chk($sformatf("r%0d_scnt", i),   stall_cnt,         32'(tbl[i].e_scnt));
         chk($sformatf("r%0d_fcnt", i),   flush_cnt,         32'(tbl[i].e_fcnt));
      end

      // No-forwarding instance: add x3 then a user of x3 stalls two cycles.
      @(negedge clk);
      rst = 1'b1;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("nf_rst_scnt", 32'(stall_cnt0), 0);
      @(negedge clk);
      rst = 1'b0;
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
      #1 chk("nf_prod_stall", 32'(stall0), 0);
      @(negedge clk);
      drive(1, 3, 0, 1, 0, 12, 1, 0, 0);
      #1;
      chk("nf_stall1",  32'(stall0), 1);
      chk("nf_bubble1", 32'(bubble0), 1);
      @(negedge clk); #1;
      chk("nf_stall2",  32'(stall0), 1);
      chk("nf_scnt1",   32'(stall_cnt0), 1);
      @(negedge clk); #1;
      chk("nf_stall3",  32'(stall0), 0);
      chk("nf_bubble3", 32'(bubble0), 0);
      chk("nf_scnt2",   32'(stall_cnt0), 2);
      @(negedge clk);
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("nf_a_sel", 32'(a_sel0), 0);
      chk("nf_b_sel", 32'(b_sel0), 0);

      // Two more stall cycles: 2-bit counter saturates at 3.
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 3, 1, 0, 0);
      @(negedge clk);
      drive(1, 0, 3, 0, 1, 0, 0, 0, 0);
      #1 chk("nf_sat_stall", 32'(stall0), 1);
      @(negedge clk); #1;
      chk("nf_sat_scnt3", 32'(stall_cnt0), 3);
      chk("nf_sat_stall2", 32'(stall0), 1);
      @(negedge clk); #1;
      chk("nf_sat_hold", 32'(stall_cnt0), 3);
      chk("nf_sat_done", 32'(stall0), 0);

      // Reset asserted in the middle of a stall clears everything at once.
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 4, 1, 0, 0);
      @(negedge clk);
      drive(1, 4, 0, 1, 0, 13, 1, 0, 0);
      #1 chk("nf_mid_stall", 32'(stall0), 1);
      #1 rst = 1'b1;
      #1;
      chk("mid_rst_stall",  32'(stall0), 0);
      chk("mid_rst_flush",  32'(flush0), 0);
      chk("mid_rst_bubble", 32'(bubble0), 0);
      chk("mid_rst_a",      32'(a_sel0), 0);
      chk("mid_rst_b",      32'(b_sel0), 0);
      chk("mid_rst_scnt",   32'(stall_cnt0), 0);
      chk("mid_rst_fcnt",   32'(flush_cnt0), 0);
      chk("mid_rst_scnt1",  stall_cnt, 0);
      chk("mid_rst_fcnt1",  flush_cnt, 0);
      @(negedge clk);
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
